// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, ALU select codes,
// flag bit positions and FSM state encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_LSL = 4'd5,
        OP_LSR = 4'd6,
        OP_ADC = 4'd7,
        OP_SBC = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    localparam logic [SEL_W-1:0] SEL_ZERO = 5'b00000;
    localparam logic [SEL_W-1:0] SEL_ADD  = 5'b10000;
    localparam logic [SEL_W-1:0] SEL_SUB  = 5'b10010;
    localparam logic [SEL_W-1:0] SEL_AND  = 5'b01000;
    localparam logic [SEL_W-1:0] SEL_OR   = 5'b00100;
    localparam logic [SEL_W-1:0] SEL_XOR  = 5'b01100;
    localparam logic [SEL_W-1:0] SEL_LSL  = 5'b11000;
    localparam logic [SEL_W-1:0] SEL_LSR  = 5'b10100;

    // Status/flag bit positions, packed as {N,V,C,Z}.
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    localparam logic [CNT_W-1:0] MUL_LAST = 6'd63;

    typedef enum logic [1:0] {
        CIN_ZERO,
        CIN_ONE,
        CIN_FLAG
    } cin_src_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_e;

    // Multiply only reports N and Z; carry and overflow are defined as clear.
    function automatic logic [FLAG_W-1:0] mul_status(input logic [DATA_W-1:0] r);
        logic [FLAG_W-1:0] s;
        s         = '0;
        s[FLAG_Z] = (r == '0);
        s[FLAG_N] = r[DATA_W-1];
        return s;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and result handshake bundle of the ALU sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [FLAG_W-1:0] res_status;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_status, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_status, res_err
    );

endinterface

// File: rtl/alu_sequencer_op_decode.sv
// Combinational opcode decoder: ALU select code, carry-in source, legality and
// whether the op runs on the multi-cycle multiply path.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic [OP_W-1:0]  cmd_op,
    output logic [SEL_W-1:0] sel,
    output cin_src_e         cin_src,
    output logic             legal,
    output logic             is_mul
);

    always_comb begin
        sel     = SEL_ZERO;
        cin_src = CIN_ZERO;
        legal   = 1'b1;
        is_mul  = 1'b0;
        case (cmd_op)
            OP_ADD: sel = SEL_ADD;
            OP_SUB: begin
                sel     = SEL_SUB;
                cin_src = CIN_ONE;
            end
            OP_AND: sel = SEL_AND;
            OP_OR:  sel = SEL_OR;
            OP_XOR: sel = SEL_XOR;
            OP_LSL: sel = SEL_LSL;
            OP_LSR: sel = SEL_LSR;
            OP_ADC: begin
                sel     = SEL_ADD;
                cin_src = CIN_FLAG;
            end
            OP_SBC: begin
                sel     = SEL_SUB;
                cin_src = CIN_FLAG;
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    sel    = SEL_ADD;
                    is_mul = 1'b1;
                end else begin
                    legal  = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single-cycle ops and a 64-step shift-add multiply through an
// external ALU, holding each result until the consumer takes it.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    alu_sequencer_if.slave     bus,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic               alu_cin,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [FLAG_W-1:0]  alu_status,
    output logic [FLAG_W-1:0]  flags
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    cin_src_e          cin_src_q, cin_src_d;
    logic              legal_q, legal_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [FLAG_W-1:0] res_status_q, res_status_d;
    logic              res_err_q, res_err_d;
    logic [FLAG_W-1:0] flags_q, flags_d;

    logic [SEL_W-1:0]  dec_sel;
    cin_src_e          dec_cin_src;
    logic              dec_legal;
    logic              dec_is_mul;
    logic              accept;

    alu_op_decode #(
        .MUL_EN (MUL_EN)
    ) u_decode (
        .cmd_op  (bus.cmd_op),
        .sel     (dec_sel),
        .cin_src (dec_cin_src),
        .legal   (dec_legal),
        .is_mul  (dec_is_mul)
    );

    assign accept = bus.cmd_valid && (state_q == S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= SEL_ZERO;
            cin_src_q    <= CIN_ZERO;
            legal_q      <= 1'b0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            res_data_q   <= '0;
            res_status_q <= '0;
            res_err_q    <= 1'b0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            cin_src_q    <= cin_src_d;
            legal_q      <= legal_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_err_q    <= res_err_d;
            flags_q      <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = dec_is_mul ? S_MUL : S_EXEC;
            S_EXEC: state_d = S_DONE;
            S_MUL:  if (cnt_q == MUL_LAST) state_d = S_DONE;
            S_DONE: if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The op is stored in decoded form; the multiplier state is seeded at accept.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        cin_src_d    = cin_src_q;
        legal_d      = legal_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_err_d    = res_err_q;
        flags_d      = flags_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d       = bus.cmd_a;
                    b_d       = bus.cmd_b;
                    sel_d     = dec_sel;
                    cin_src_d = dec_cin_src;
                    legal_d   = dec_legal;
                    acc_d     = '0;
                    mcand_d   = bus.cmd_a;
                    mplier_d  = bus.cmd_b;
                    cnt_d     = '0;
                end
            end
            S_EXEC: begin
                if (legal_q) begin
                    res_data_d   = alu_out;
                    res_status_d = alu_status;
                    res_err_d    = 1'b0;
                    flags_d      = alu_status;
                end else begin
                    res_data_d   = '0;
                    res_status_d = '0;
                    res_err_d    = 1'b1;
                end
            end
            S_MUL: begin
                acc_d    = mplier_q[0] ? alu_out : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == MUL_LAST) begin
                    res_data_d   = acc_d;
                    res_status_d = mul_status(acc_d);
                    res_err_d    = 1'b0;
                    flags_d      = mul_status(acc_d);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_sel = SEL_ZERO;
        case (state_q)
            S_EXEC: begin
                alu_a = a_q;
                alu_b = b_q;
                if (legal_q) begin
                    alu_sel = sel_q;
                    case (cin_src_q)
                        CIN_ONE:  alu_cin = 1'b1;
                        CIN_FLAG: alu_cin = flags_q[FLAG_C];
                        default:  alu_cin = 1'b0;
                    endcase
                end
            end
            S_MUL: begin
                alu_a   = acc_q;
                alu_b   = mcand_q;
                alu_sel = SEL_ADD;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.res_valid  = (state_q == S_DONE);
    assign bus.res_data   = res_data_q;
    assign bus.res_status = res_status_q;
    assign bus.res_err    = res_err_q;
    assign flags          = flags_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: MUL_EN, 1, 1 enables the multi-cycle MUL opcode and 0 makes opcode 9 illegal.
REQ-002 SHALL have port: clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  in  1  command present.
REQ-005 SHALL have port: cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-006 SHALL have port: cmd_op  in  4  opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSL, 6 LSR, 7 ADC, 8 SBC, 9 MUL, 10-15 illegal).
REQ-007 SHALL have ports: cmd_a and cmd_b  in  64  operands A and B.
REQ-008 SHALL have port: res_valid  out  1  result available.
REQ-009 SHALL have port: res_ready  in  1  consumer takes the result.
REQ-010 SHALL have ports: res_data  out  64 and res_status  out  4  result value and flags {N,V,C,Z}.
REQ-011 SHALL have port: res_err  out  1  the result belongs to an illegal opcode.
REQ-012 SHALL have ports to the ALU: alu_a  out  64, alu_b  out  64, alu_cin  out  1, alu_sel  out  5; and from the ALU: alu_out  in  64, alu_status  in  4 (bit0 Z, bit1 C, bit2 V, bit3 N).
REQ-013 SHALL have port: flags  out  4  architectural flag register {N,V,C,Z}.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, MUL and DONE, with cmd_ready = (state==IDLE).
REQ-015 On accept (cmd_valid&&cmd_ready), SHALL latch op, A and B, and go to MUL if op==9&&MUL_EN, otherwise go to EXEC.
REQ-016 SHALL use these alu_sel/alu_cin encodings: ADD 10000/0, SUB 10010/1, AND 01000/0, OR 00100/0, XOR 01100/0, LSL 11000/0, LSR 10100/0, ADC 10000/flags.C, SBC 10010/flags.C.
REQ-017 In EXEC, SHALL drive alu_a=A and alu_b=B, capture alu_out to res_data and alu_status to res_status, and then go to DONE; the EXEC state lasts exactly one cycle.
REQ-018 Illegal op: in EXEC, SHALL drive alu_sel=00000, set res_data=0, res_status=0000 and res_err=1, and leave flags unchanged; the op SHALL have the same latency as a legal op.
REQ-019 MUL SHALL run exactly 64 cycles. Each cycle it SHALL drive alu_a=acc, alu_b=mcand and the ADD encoding, with acc<=alu_out if mplier[0]. It SHALL then shift mcand<<1 and mplier>>1. acc SHALL be initialised to 0, mcand to A and mplier to B.
REQ-020 MUL result SHALL be the low 64 bits of A*B. Its status SHALL be Z=(result==0), N=result[63] and C=V=0.
REQ-021 Latency: for an accept at cycle T, res_valid SHALL go high at T+2 for a single-cycle op and at T+65 for MUL.
REQ-022 In DONE, res_valid=1 and res_data/res_status/res_err SHALL be held stable until res_ready=1; then the FSM SHALL go to IDLE on the next edge.
REQ-023 On completion of a legal op, flags SHALL be loaded from res_status in the same edge that enters DONE.
REQ-024 In IDLE and DONE, SHALL drive alu_sel=00000, alu_cin=0 and alu_a=alu_b=0.
REQ-025 SHALL not accept a new command in the cycle in which DONE hands off; there is no back-to-back overlap.
REQ-026 Shift amount SHALL be B[5:0], with wrap handled by the ALU; shifts of 64 or more are not possible.

Reset
REQ-027 Reset SHALL force state=IDLE, flags=0000, res_valid=0, res_data=0, res_status=0, res_err=0 and all ALU drive outputs to 0.
REQ-028 Reset during EXEC, MUL or DONE SHALL discard the operation; cmd_ready SHALL be 1 in the cycle after reset deasserts.
REQ-029 Reset SHALL take priority over a simultaneous accept or handoff.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode enum, the alu_sel constants (SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_XOR, SEL_LSL, SEL_LSR, SEL_ZERO) and the flag bit indices.
REQ-031 SHALL include one combinational sub-module, alu_op_decode: cmd_op and MUL_EN -> sel, cin_src, legal, is_mul.

Verification
REQ-032 ADD 5+7 -> res_data=12 and res_status=0000, with res_valid at T+2.
REQ-033 SUB 3-3 -> res_data=0 and res_status=0011 (Z,C); flags=0011.
REQ-034 ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> res_data=0x8000_0000_0000_0000 and res_status=1100.
REQ-035 ADD 0xFFFF_FFFF_FFFF_FFFF+1 (flags C=1), then ADC 0+0 -> res_data=1.
REQ-036 MUL 0x1234*0x10 -> 0x12340 with res_valid at exactly T+65; holding res_ready low for 3 cycles SHALL leave the outputs stable.
REQ-037 Reset at MUL cycle 30 -> res_valid stays 0, flags=0000 and cmd_ready=1 next cycle. Then op 15 -> res_err=1, res_data=0 and flags unchanged.
